// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud settings.
// Imported by the transmitter, the receiver and the baud generator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam int DEF_DBIT     = 8;
    localparam int DEF_SB_TICK  = 16;
    localparam int DEF_BAUD_DIV = 326;

endpackage

// File: rtl/baud_gen.sv
// Free-running mod-BAUD_DIV counter producing a one-clock 16x-oversampling tick.
// Shared by the UART transmitter and receiver.
module baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: shifts a captured byte out LSB-first, one bit per
// 16 baud ticks, with a registered line output and a done pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT     = DEF_DBIT,
    parameter int SB_TICK  = DEF_SB_TICK,
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]    S_BIT  = 5'd15;
    localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    state_t          state, state_n;
    logic [4:0]      s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            tx_n, busy_n, done_n;
    logic            tick;

    baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            tx           <= tx_n;
            tx_busy      <= busy_n;
            tx_done_tick <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_start) begin
                    b_n     = din;
                    s_n     = '0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_BIT) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = DATA;
                    end else begin
                        s_n = s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == S_BIT) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == N_LAST)
                            state_n = STOP;
                        else
                            n_n = n + NW'(1);
                    end else begin
                        s_n = s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == S_STOP) begin
                        // leave s cleared so idle ticks see it at 0
                        s_n     = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        s_n = s + 5'd1;
                    end
                end
            end
        endcase
    end

    // Line level follows the state being entered, so tx stays registered.
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        unique case (state_n)
            IDLE:  tx_n = 1'b1;
            START: tx_n = 1'b0;
            DATA:  tx_n = b_n[0];
            STOP:  tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level model counts baud ticks
// since acceptance and predicts tx/tx_busy/tx_done_tick every clock.
module tb_uart_tx;

    localparam int DIV   = 4;
    localparam int DB    = 8;
    localparam int SBT   = 16;
    localparam int TOTAL = 16 * (1 + DB) + SBT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_start = 1'b0;
    logic [DB-1:0] din = '0;
    logic          tx;
    logic          tx_busy;
    logic          tx_done_tick;

    int checks = 0;
    int failures = 0;

    int            phase = 0;
    int            ticks = 0;
    bit            m_busy = 1'b0;
    bit            m_tx = 1'b1;
    bit            m_done = 1'b0;
    logic [DB-1:0] m_data = '0;
    int            done_cnt = 0;
    int            base;

    uart_tx #(
        .DBIT     (DB),
        .SB_TICK  (SBT),
        .BAUD_DIV (DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    // Line level for frame bit slot i: start, data LSB first, then stop.
    function automatic bit frame_bit(int i, logic [DB-1:0] d);
        if (i == 0)
            return 1'b0;
        else if (i <= DB)
            return d[i-1];
        else
            return 1'b1;
    endfunction

    task automatic clock();
        bit tk;
        @(posedge clk);
        if (!rst_n) begin
            phase  = 0;
            m_busy = 1'b0;
            m_tx   = 1'b1;
            m_done = 1'b0;
        end else begin
            tk     = (phase == DIV - 1);
            phase  = (phase + 1) % DIV;
            m_done = 1'b0;
            if (!m_busy) begin
                if (tx_start) begin
                    m_busy = 1'b1;
                    ticks  = 0;
                    m_data = din;
                    m_tx   = 1'b0;
                end
            end else if (tk) begin
                ticks++;
                if (ticks == TOTAL) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_tx   = 1'b1;
                end else begin
                    m_tx = frame_bit(ticks / 16, m_data);
                end
            end
        end
        #1;
        if (tx_done_tick === 1'b1)
            done_cnt++;
        checks += 3;
        assert (tx === m_tx) else begin
            failures++;
            $error("FAIL tx t=%0t got %b exp %b", $time, tx, m_tx);
        end
        assert (tx_busy === m_busy) else begin
            failures++;
            $error("FAIL busy t=%0t got %b exp %b", $time, tx_busy, m_busy);
        end
        assert (tx_done_tick === m_done) else begin
            failures++;
            $error("FAIL done t=%0t got %b exp %b", $time, tx_done_tick, m_done);
        end
    endtask

    task automatic run(int cyc);
        repeat (cyc) clock();
    endtask

    task automatic check_done(string tag, int exp);
        checks++;
        assert (done_cnt - base === exp) else begin
            failures++;
            $error("FAIL %s done_count got %0d exp %0d", tag, done_cnt - base, exp);
        end
    endtask

    initial begin
        // reset, then idle with ticks running
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(40);

        // 0x55 single frame
        base = done_cnt;
        din = 8'h55;
        tx_start = 1'b1;
        clock();
        tx_start = 1'b0;
        run(TOTAL * DIV + 10);
        check_done("frame55", 1);

        // 0x80, din disturbed mid-frame
        base = done_cnt;
        din = 8'h80;
        tx_start = 1'b1;
        clock();
        tx_start = 1'b0;
        run(200);
        din = 8'hFF;
        run(TOTAL * DIV - 190);
        check_done("frame80", 1);

        // back-to-back with tx_start held
        base = done_cnt;
        din = 8'hA3;
        tx_start = 1'b1;
        clock();
        din = 8'h3C;
        run(700);
        tx_start = 1'b0;
        run(650);
        check_done("b2b", 2);

        // tx_start pulse during DATA is ignored
        base = done_cnt;
        din = 8'($urandom);
        tx_start = 1'b1;
        clock();
        tx_start = 1'b0;
        run(300);
        din = 8'($urandom);
        tx_start = 1'b1;
        clock();
        tx_start = 1'b0;
        run(TOTAL * DIV);
        check_done("ignore", 1);

        // reset during data bit 3 aborts the frame
        base = done_cnt;
        din = 8'($urandom);
        tx_start = 1'b1;
        clock();
        tx_start = 1'b0;
        run(280);
        rst_n = 1'b0;
        clock();
        rst_n = 1'b1;
        run(700);
        check_done("abort", 0);

        // fresh frame after the abort
        base = done_cnt;
        din = 8'($urandom);
        tx_start = 1'b1;
        clock();
        tx_start = 1'b0;
        run(TOTAL * DIV + 10);
        check_done("postrst", 1);

        // random bytes with random idle gaps
        for (int i = 0; i < 4; i++) begin
            base = done_cnt;
            run(int'($urandom_range(0, 9)));
            din = 8'($urandom);
            tx_start = 1'b1;
            clock();
            tx_start = 1'b0;
            run(TOTAL * DIV + 5);
            check_done("rand", 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
